// File: rtl/pipeline_drain_buffer.sv
// pipeline_drain_buffer: credit-managed first-word-fall-through FIFO sitting behind a fixed-latency,
// non-stallable pipeline. Define PIPELINE_DRAIN_BUFFER_STATUS_EN to add the LEVEL/HWM status outputs.
module pipeline_drain_buffer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ISSUE,
    output logic             ISSUE_OK,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             ERR
`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic [$clog2(DEPTH+1)-1:0] HWM
`endif
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);

    // Every in-flight word needs a slot, and pointer wrap relies on a power-of-two depth.
    if (DEPTH < LATENCY + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pipeline_drain_buffer: DEPTH must be a power of 2 and >= LATENCY+2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          err_q, err_d;

    logic [CW:0] credit_sum;
    logic        issue_acc;
    logic        issue_viol;
    logic        unsolicited;
    logic        pop;
    logic        push;
    logic        drop;

    // Output handshake: a word transfers on any cycle with O_VALID & O_READY; O_VALID depends only on
    // registered state, and O_READY while O_VALID is low has no effect.
    assign credit_sum  = {1'b0, count_q} + {1'b0, inflight_q};
    assign ISSUE_OK    = credit_sum < DEPTH_X;
    assign issue_acc   = ISSUE & ISSUE_OK;
    assign issue_viol  = ISSUE & ~ISSUE_OK;
    assign unsolicited = D_VALID & (inflight_q == '0);

    assign O_VALID = (count_q != '0);
    assign O       = mem_q[rd_ptr_q];
    assign ERR     = err_q;

    // A full FIFO can still take a word when the head leaves on the same cycle.
    assign pop  = O_VALID & O_READY;
    assign push = D_VALID & ((count_q < DEPTH_C) | pop);
    assign drop = D_VALID & ~push;

    always_comb begin
        inflight_d = inflight_q;
        if (issue_acc && !D_VALID) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue_acc && D_VALID && inflight_q != '0) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    assign err_d = err_q | issue_viol | unsolicited | drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q    <= '0;
            inflight_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
        end
    end

    // Storage carries no reset; O is only meaningful while O_VALID is high.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= D;
        end
    end

`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
    logic [CW-1:0] hwm_q, hwm_d;

    assign hwm_d = (count_d > hwm_q) ? count_d : hwm_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign LEVEL = count_q;
    assign HWM   = hwm_q;
`endif

endmodule

// File: tb/tb_pipeline_drain_buffer.sv
// Self-checking bench for pipeline_drain_buffer: a queue-based reference model plus a modelled
// LATENCY-deep upstream pipeline; LEVEL/HWM are checked when PIPELINE_DRAIN_BUFFER_STATUS_EN is defined.
module tb_pipeline_drain_buffer;

    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int DEP = 8;
    localparam int CW  = $clog2(DEP + 1);

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         ISSUE;
    logic         ISSUE_OK;
    logic [W-1:0] D;
    logic         D_VALID;
    logic [W-1:0] O;
    logic         O_VALID;
    logic         O_READY;
    logic         ERR;
`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
    logic [CW-1:0] LEVEL;
    logic [CW-1:0] HWM;
`endif

    pipeline_drain_buffer #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ISSUE    (ISSUE),
        .ISSUE_OK (ISSUE_OK),
        .D        (D),
        .D_VALID  (D_VALID),
        .O        (O),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY),
        .ERR      (ERR)
`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
        ,
        .LEVEL    (LEVEL),
        .HWM      (HWM)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model state: stored words, outstanding credits, sticky error, high-water mark.
    logic [W-1:0] exp_q[$];
    int           m_inflight;
    logic         m_err;
    int           m_hwm;
    logic         pipe_v [LAT];
    logic [W-1:0] pipe_d [LAT];
    logic [W-1:0] next_word;
    int           pop_cnt;
    int           tests;
    int           fails;

    function automatic bit m_ok();
        return (exp_q.size() + m_inflight) < DEP;
    endfunction

    task automatic apply_reset();
        RST_N   = 1'b0;
        ISSUE   = 1'b0;
        D_VALID = 1'b0;
        D       = '0;
        O_READY = 1'b0;
        exp_q.delete();
        m_inflight = 0;
        m_err      = 1'b0;
        m_hwm      = 0;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        next_word = W'(1);
        pop_cnt   = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // One clock: drive inputs, score outputs against the model, advance model and upstream pipeline.
    task automatic drive_cycle(input logic iss, input logic rdy, input logic fdv, input logic [W-1:0] fd);
        logic         dv;
        logic [W-1:0] dd;
        bit           ok;
        bit           pop;
        bit           push;
        dv = pipe_v[0] | fdv;
        dd = fdv ? fd : pipe_d[0];
        ISSUE   = iss;
        O_READY = rdy;
        D_VALID = dv;
        D       = dd;
        ok = m_ok();
        tests++;
        if (ISSUE_OK !== ok) begin
            fails++;
            $display("FAIL issue_ok: got %b expected %b", ISSUE_OK, ok);
        end
        tests++;
        if (O_VALID !== (exp_q.size() != 0)) begin
            fails++;
            $display("FAIL o_valid: got %b expected %b", O_VALID, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            tests++;
            if (O !== exp_q[0]) begin
                fails++;
                $display("FAIL o_data: got %0h expected %0h", O, exp_q[0]);
            end
        end
        pop  = (exp_q.size() != 0) && rdy;
        push = dv && ((exp_q.size() < DEP) || pop);
        if (iss && !ok) m_err = 1'b1;
        if (dv && m_inflight == 0) m_err = 1'b1;
        if (dv && !push) m_err = 1'b1;
        if (iss && ok) m_inflight++;
        if (dv && m_inflight > 0) m_inflight--;
        if (pop) begin
            void'(exp_q.pop_front());
            pop_cnt++;
        end
        if (push) exp_q.push_back(dd);
        if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
        for (int i = 0; i < LAT - 1; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_d[i] = pipe_d[i+1];
        end
        pipe_v[LAT-1] = iss;
        pipe_d[LAT-1] = next_word;
        if (iss) next_word = next_word + W'(1);
        @(posedge CLK);
        #1;
        tests++;
        if (ERR !== m_err) begin
            fails++;
            $display("FAIL err: got %b expected %b", ERR, m_err);
        end
`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
        tests++;
        if (LEVEL !== CW'(exp_q.size())) begin
            fails++;
            $display("FAIL level: got %0d expected %0d", LEVEL, exp_q.size());
        end
        tests++;
        if (HWM !== CW'(m_hwm)) begin
            fails++;
            $display("FAIL hwm: got %0d expected %0d", HWM, m_hwm);
        end
`endif
    endtask

    task automatic fill_legal(input int n);
        for (int i = 0; i < n; i++) drive_cycle(m_ok(), 1'b0, 1'b0, '0);
        repeat (LAT) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) drive_cycle(m_ok() & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if (O_VALID !== 1'b0 || ERR !== 1'b0 || ISSUE_OK !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got v=%b e=%b ok=%b expected v=0 e=0 ok=1", O_VALID, ERR, ISSUE_OK);
        end
        apply_reset();
        tests++;
        if (O_VALID !== 1'b0 || ERR !== 1'b0 || ISSUE_OK !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got v=%b e=%b ok=%b expected v=0 e=0 ok=1", O_VALID, ERR, ISSUE_OK);
        end
    endtask

    task automatic test_credit_and_stall();
        int accepted;
        apply_reset();
        accepted = 0;
        for (int i = 0; i < 20 && m_ok(); i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, '0);
            accepted++;
        end
        tests++;
        if (accepted !== 8 || ISSUE_OK !== 1'b0) begin
            fails++;
            $display("FAIL credit_limit: got %0d issues ok=%b expected 8 issues ok=0", accepted, ISSUE_OK);
        end
        repeat (LAT + 2) drive_cycle(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (O_VALID !== 1'b1 || O !== W'(i + 1)) begin
                fails++;
                $display("FAIL stall_drain: got v=%b %0h expected v=1 %0h", O_VALID, O, i + 1);
            end
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        tests++;
        if (O_VALID !== 1'b0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL stall_empty: got v=%b e=%b expected v=0 e=0", O_VALID, ERR);
        end
    endtask

    task automatic test_streaming();
        int first_pop;
        apply_reset();
        first_pop = -1;
        for (int c = 0; c < 100; c++) begin
            if (O_VALID === 1'b1 && first_pop < 0) first_pop = c;
            drive_cycle(1'b1, 1'b1, 1'b0, '0);
        end
        tests++;
        if (first_pop !== 3 || pop_cnt !== 97 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL streaming: got first=%0d pops=%0d e=%b expected first=3 pops=97 e=0", first_pop, pop_cnt, ERR);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] want;
        apply_reset();
        fill_legal(8);
        for (int i = 0; i < 20; i++) begin
            want = (i < 8) ? W'(i + 1) : W'(32'h100 + i - 8);
            tests++;
            if (O_VALID !== 1'b1 || O !== want) begin
                fails++;
                $display("FAIL wrap_order: got v=%b %0h expected v=1 %0h", O_VALID, O, want);
            end
            drive_cycle(1'b0, 1'b1, 1'b1, W'(32'h100 + i));
        end
        tests++;
        if (O_VALID !== 1'b1 || ISSUE_OK !== 1'b0 || O !== W'(32'h10c)) begin
            fails++;
            $display("FAIL wrap_full: got v=%b ok=%b %0h expected v=1 ok=0 10c", O_VALID, ISSUE_OK, O);
        end
    endtask

    task automatic test_errors();
        // (a) issue without credit
        apply_reset();
        fill_legal(8);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        repeat (LAT + 1) drive_cycle(1'b0, 1'b0, 1'b0, '0);
        tests++;
        if (ERR !== 1'b1) begin
            fails++;
            $display("FAIL err_issue: got %b expected 1", ERR);
        end
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (ERR !== 1'b1 || O_VALID !== 1'b0) begin
            fails++;
            $display("FAIL err_sticky: got e=%b v=%b expected e=1 v=0", ERR, O_VALID);
        end
        // (b) unsolicited arrival
        apply_reset();
        tests++;
        if (ERR !== 1'b0) begin
            fails++;
            $display("FAIL err_cleared: got %b expected 0", ERR);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, W'(32'hdead));
        tests++;
        if (ERR !== 1'b1) begin
            fails++;
            $display("FAIL err_unsolicited: got %b expected 1", ERR);
        end
        // (c) push into a full FIFO with no pop
        apply_reset();
        fill_legal(8);
        drive_cycle(1'b0, 1'b0, 1'b1, W'(32'hbad));
        tests++;
        if (ERR !== 1'b1) begin
            fails++;
            $display("FAIL err_overflow: got %b expected 1", ERR);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (O !== W'(i + 1)) begin
                fails++;
                $display("FAIL overflow_drop: got %0h expected %0h", O, i + 1);
            end
            drive_cycle(1'b0, 1'b1, 1'b0, '0);
        end
        tests++;
        if (O_VALID !== 1'b0 || ERR !== 1'b1) begin
            fails++;
            $display("FAIL overflow_end: got v=%b e=%b expected v=0 e=1", O_VALID, ERR);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive_cycle(m_ok() & ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50), 1'b0, '0);
        end
        repeat (LAT + DEP + 2) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (ERR !== 1'b0 || O_VALID !== 1'b0 || pop_cnt !== int'(next_word) - 1) begin
            fails++;
            $display("FAIL random_end: got e=%b v=%b pops=%0d expected e=0 v=0 pops=%0d", ERR, O_VALID, pop_cnt, int'(next_word) - 1);
        end
    endtask

`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
    task automatic test_status();
        apply_reset();
        fill_legal(5);
        for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        tests++;
        if (LEVEL !== CW'(0) || HWM !== CW'(5)) begin
            fails++;
            $display("FAIL status_hwm: got level=%0d hwm=%0d expected level=0 hwm=5", LEVEL, HWM);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        apply_reset();
        test_reset();
        test_credit_and_stall();
        test_streaming();
        test_wrap();
        test_errors();
        test_random();
`ifdef PIPELINE_DRAIN_BUFFER_STATUS_EN
        test_status();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_drain_buffer.md
Name: pipeline_drain_buffer

Overview:
- Credit-managed FIFO directly downstream of a fixed-latency, non-stallable delay pipeline (clock enable held high).
- The producer issues words into the pipeline head only while ISSUE_OK is high. Words emerge LATENCY cycles later on D/D_VALID and are captured here.
- The block guarantees every in-flight word has a free slot when it arrives, so downstream backpressure (O_READY low) never drops data.
- Output is first-word-fall-through with a valid/ready handshake.

Parameters:
- WIDTH, 32, data width of D and O.
- LATENCY, 2, upstream pipeline latency in cycles; used only for the DEPTH legality check.
- DEPTH, 8, FIFO entries; power of 2, must be >= LATENCY+2. Elaboration fails otherwise.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ISSUE  input  1  producer pushed one word into the upstream pipeline head this cycle.
- ISSUE_OK  output  1  a credit is available; the producer may assert ISSUE this cycle.
- D  input  WIDTH  data from the upstream pipeline output.
- D_VALID  input  1  D carries a word this cycle (ISSUE delayed by the same pipeline).
- O  output  WIDTH  head-of-FIFO data.
- O_VALID  output  1  FIFO non-empty.
- O_READY  input  1  consumer accepts O this cycle.
- ERR  output  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous on RST_N low, released synchronously to CLK):
  - count=0, inflight=0, rd_ptr=0, wr_ptr=0, ERR=0, O_VALID=0, ISSUE_OK=1.
  - Storage array is not reset. O is don't-care while O_VALID=0.
- Counter widths: clog2(DEPTH+1) bits for count and inflight.
- Credit rule: ISSUE_OK = (count + inflight) < DEPTH.
  - Computed combinationally from registered count and inflight only; no dependency on ISSUE, D_VALID or O_READY in the same cycle.
- Issue:
  - ISSUE & ISSUE_OK: inflight+1.
  - ISSUE & !ISSUE_OK: inflight unchanged, ERR<=1.
- Arrival:
  - D_VALID: inflight-1, saturating at 0.
  - D_VALID with inflight==0: ERR<=1 (unsolicited word).
- Simultaneous ISSUE & D_VALID: inflight unchanged (the +1 and -1 cancel).
- Push (D_VALID):
  - Accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Accepted push: mem[wr_ptr]<=D, wr_ptr+1, wrapping modulo DEPTH.
  - Rejected push: word dropped, ERR<=1, pointers unchanged.
- Pop (O_VALID & O_READY): rd_ptr+1, wrapping modulo DEPTH.
- count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- O_VALID = (count != 0), registered-count based.
- O = mem[rd_ptr], combinational read (FWFT).
- Pass-through latency: a word pushed on cycle N appears on O/O_VALID on cycle N+1 when the FIFO was empty.
- O_READY while O_VALID=0: ignored, no state change.
- ERR clears only on reset.
- Reset mid-operation: all in-flight and stored words are discarded. Upstream pipeline contents arriving after reset release count as unsolicited (ERR<=1); the producer must flush the upstream pipeline when resetting.
- Correct-use invariant: count + inflight <= DEPTH at all times, so ERR never sets.

Optional Feature:
- Macro: PIPELINE_DRAIN_BUFFER_STATUS_EN.
- Defined, adds two outputs:
  - LEVEL (clog2(DEPTH+1) bits): registered count.
  - HWM (same width): registered high-water mark of count since reset. Updates to max(HWM, next count) each cycle. Reset value 0.
- Not defined: ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: RST_N low mid-traffic, then release -> O_VALID=0, ERR=0, ISSUE_OK=1. With LATENCY=2, DEPTH=8 and ISSUE held high (O_READY=0), ISSUE_OK falls after exactly 8 accepted issues.
- Stall absorption: O_READY=0, issue 8 words 0x1..0x8 obeying ISSUE_OK, delayed 2 cycles on D_VALID -> count=8, no drop, ERR=0. Then O_READY=1 -> O yields 0x1..0x8 in order on 8 consecutive cycles.
- Streaming: ISSUE and O_READY held high for 100 cycles -> ISSUE_OK stays 1, one word out per cycle after 3-cycle fill (LATENCY plus FWFT), ERR=0.
- Wrap-around with full push/pop: fill to 8 with O_READY=0, then pop and push on the same cycle for 20 cycles -> count stays 8, data order preserved across pointer wrap.
- Protocol errors, each from reset: (a) ISSUE while ISSUE_OK=0; (b) D_VALID with inflight=0; (c) D_VALID when count=8 with no pop -> ERR=1 after each case, word dropped in (c), ERR holds until RST_N.
- With PIPELINE_DRAIN_BUFFER_STATUS_EN: fill to 5, drain to 0 -> LEVEL tracks count each cycle, HWM=5 persists after drain.
